// File: rtl/led_pwm_pkg.sv
// Shared register map, duty type and sizing helper for the LED PWM controller.
package led_pwm_pkg;

    localparam logic [6:0] ENABLE_ADDR       = 7'h00;
    localparam logic [6:0] MODE_ADDR         = 7'h04;
    localparam logic [6:0] BLINK_PERIOD_ADDR = 7'h08;
    localparam logic [6:0] STATUS_ADDR       = 7'h0C;
    localparam logic [6:0] DUTY_BASE_ADDR    = 7'h20;

    localparam int BLINK_WIDTH = 16;

    // One duty byte lane on the bus; channels use the low PwmWidth bits.
    typedef logic [7:0] duty_t;

    function automatic int num_duty_words(input int num_leds);
        return (num_leds + 3) / 4;
    endfunction

endpackage

// File: rtl/led_pwm_channel.sv
// One LED channel: programmed duty, period-aligned shadow duty, PWM compare and output flop.
module led_pwm_channel
    import led_pwm_pkg::*;
#(
    parameter int PwmWidth = 8
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                duty_write,
    input  logic [PwmWidth-1:0] duty_data,
    input  logic [PwmWidth-1:0] pwm_cnt,
    input  logic                pwm_wrap,
    input  logic                enable,
    input  logic                blink_mode,
    input  logic                blink_phase,
    output duty_t               duty_readback,
    output logic                led
);

    logic [PwmWidth-1:0] duty_q;
    logic [PwmWidth-1:0] shadow_q;
    logic                pwm_on;

    // All-ones duty is treated as solid on, so full brightness has no dark slot.
    assign pwm_on        = (&shadow_q) || (pwm_cnt < shadow_q);
    assign duty_readback = duty_t'(duty_q);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: duty state is a handful of flops, not a RAM, so it can and must be reset; all-ones keeps the old on/off behaviour.
            duty_q   <= '1;
            shadow_q <= '1;
            led      <= 1'b0;
        end else begin
            if (duty_write) duty_q <= duty_data;
            if (pwm_wrap)   shadow_q <= duty_q;
            led <= enable & pwm_on & (~blink_mode | blink_phase);
        end
    end

endmodule

// File: rtl/led_pwm_controller.sv
// Memory-mapped LED controller: bus decode, readback, PWM counter and blink timebase.
module led_pwm_controller
    import led_pwm_pkg::*;
#(
    parameter int NumLeds   = 4,
    parameter int PwmWidth  = 8,
    parameter int AddrWidth = 32
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [AddrWidth-1:0] addr,
    input  logic                 write_req,
    input  logic [31:0]          write_data,
    input  logic [3:0]           byte_enable,
    input  logic                 read_req,
    output logic [31:0]          read_data,
    output logic                 read_data_valid,
    output logic [NumLeds-1:0]   leds
);

    localparam int NumDutyWords = num_duty_words(NumLeds);

    logic [4:0]             word;
    logic                   unused_bits;
    logic [NumLeds-1:0]     enable_q;
    logic [NumLeds-1:0]     mode_q;
    logic [BLINK_WIDTH-1:0] blink_period_q;
    logic [BLINK_WIDTH-1:0] blink_cnt;
    logic                   blink_phase;
    logic [PwmWidth-1:0]    pwm_cnt;
    logic                   pwm_wrap;
    logic                   wr_enable;
    logic                   wr_mode;
    logic                   wr_period;
    logic [NumLeds-1:0]     led_be;
    logic [NumLeds-1:0]     enable_mask;
    logic [NumLeds-1:0]     mode_mask;
    logic [31:0]            rdata;

    logic [NumDutyWords-1:0][3:0][7:0] duty_bytes;
    logic [NumDutyWords:0][31:0]       duty_acc;

    assign word        = addr[6:2];
    assign unused_bits = ^{addr[AddrWidth-1:7], addr[1:0], write_data};

    assign wr_enable = write_req && (word == ENABLE_ADDR[6:2]);
    assign wr_mode   = write_req && (word == MODE_ADDR[6:2]);
    assign wr_period = write_req && (word == BLINK_PERIOD_ADDR[6:2]);
    assign pwm_wrap  = &pwm_cnt;

    assign enable_mask = wr_enable ? led_be : '0;
    assign mode_mask   = wr_mode   ? led_be : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            enable_q       <= '0;
            mode_q         <= '0;
            blink_period_q <= '0;
            blink_cnt      <= '0;
            blink_phase    <= 1'b0;
            pwm_cnt        <= '0;
        end else begin
            // NOTE: non-blocking assignments here so every register samples pre-edge values regardless of statement order.
            enable_q <= (enable_q & ~enable_mask) | (write_data[NumLeds-1:0] & enable_mask);
            mode_q   <= (mode_q & ~mode_mask) | (write_data[NumLeds-1:0] & mode_mask);
            if (wr_period && byte_enable[0]) blink_period_q[7:0]  <= write_data[7:0];
            if (wr_period && byte_enable[1]) blink_period_q[15:8] <= write_data[15:8];

            pwm_cnt <= pwm_cnt + 1'b1;
            // A period lowered below blink_cnt lets the counter run round 2^16 before matching.
            if (pwm_wrap) begin
                if (blink_cnt == blink_period_q) begin
                    blink_cnt   <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    blink_cnt <= blink_cnt + 1'b1;
                end
            end
        end
    end

    for (genvar g = 0; g < NumLeds; g++) begin : g_chan
        logic  duty_write;
        duty_t duty_rb;

        assign led_be[g]   = byte_enable[g / 8];
        assign duty_write  = write_req && (word == DUTY_BASE_ADDR[6:2] + 5'(g / 4))
                             && byte_enable[g % 4];
        assign duty_bytes[g / 4][g % 4] = duty_rb;

        led_pwm_channel #(
            .PwmWidth (PwmWidth)
        ) u_channel (
            .clk           (clk),
            .reset_n       (reset_n),
            .duty_write    (duty_write),
            .duty_data     (write_data[8 * (g % 4) +: PwmWidth]),
            .pwm_cnt       (pwm_cnt),
            .pwm_wrap      (pwm_wrap),
            .enable        (enable_q[g]),
            .blink_mode    (mode_q[g]),
            .blink_phase   (blink_phase),
            .duty_readback (duty_rb),
            .led           (leds[g])
        );
    end

    for (genvar g = NumLeds; g < 4 * NumDutyWords; g++) begin : g_pad
        assign duty_bytes[g / 4][g % 4] = '0;
    end

    assign duty_acc[0] = '0;
    for (genvar k = 0; k < NumDutyWords; k++) begin : g_duty_rd
        assign duty_acc[k + 1] = duty_acc[k] |
            ((word == DUTY_BASE_ADDR[6:2] + 5'(k)) ? duty_bytes[k] : 32'h0);
    end

    always_comb begin
        // NOTE: default first so every path assigns rdata and no latch is inferred.
        rdata = '0;
        case (word)
            ENABLE_ADDR[6:2]:       rdata[NumLeds-1:0] = enable_q;
            MODE_ADDR[6:2]:         rdata[NumLeds-1:0] = mode_q;
            BLINK_PERIOD_ADDR[6:2]: rdata[15:0] = blink_period_q;
            STATUS_ADDR[6:2]: begin
                rdata[0]    = blink_phase;
                rdata[15:8] = duty_t'(pwm_cnt);
            end
            default:                rdata = duty_acc[NumDutyWords];
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            read_data       <= '0;
            read_data_valid <= 1'b0;
        end else begin
            read_data_valid <= read_req;
            if (read_req) read_data <= rdata;
        end
    end

endmodule
